// File: rtl/common_credit_pkg.sv
// Shared types and constants for the credit controller and its inc/dec lookup table.
// Latency: none (package only).
// Backpressure: not applicable.
package common_credit_pkg;

    // Credit counter width: covers a shared resource of up to 31 entries.
    localparam int CRD_W = 5;

    // FSM state encodings, kept as plain constants so other blocks can decode them.
    localparam logic [1:0] CRD_ST_RUN   = 2'd0;
    localparam logic [1:0] CRD_ST_DRAIN = 2'd1;
    localparam logic [1:0] CRD_ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN   = CRD_ST_RUN,
        ST_DRAIN = CRD_ST_DRAIN,
        ST_DONE  = CRD_ST_DONE
    } crd_state_e;

    // One lookup-table word: carry/borrow flag on top, next credit value below.
    typedef struct packed {
        logic             co;
        logic [CRD_W-1:0] q;
    } crd_rom_t;

    // Contents of the inc/dec table, addressed by {dec, d}.
    // dec=1 gives d-1 (co=borrow), dec=0 gives d+1 (co=carry).
    function automatic crd_rom_t crd_decinc_entry(input logic dec, input logic [CRD_W-1:0] d);
        logic [CRD_W:0] sum;
        if (dec) begin
            sum = {1'b0, d} - {{CRD_W{1'b0}}, 1'b1};
        end else begin
            sum = {1'b0, d} + {{CRD_W{1'b0}}, 1'b1};
        end
        return crd_rom_t'(sum);
    endfunction

endpackage

// File: rtl/common_rtlrom_decinc5.sv
// Purpose: 64-word inc/dec lookup (address {dec, d}) returning d-1 or d+1 plus carry/borrow.
// Latency: purely combinational, result valid in the same cycle as the address.
// Backpressure: none; the owner decides whether the result is used.
module common_rtlrom_decinc5
    import common_credit_pkg::*;
(
    input  logic [CRD_W-1:0] d,
    input  logic             dec,
    output logic [CRD_W-1:0] q,
    output logic             co
);

    crd_rom_t rom_dat;

    // Table read; the package function defines every word, so this folds to a constant lookup.
    always_comb begin
        rom_dat = crd_decinc_entry(dec, d);
        q       = rom_dat.q;
        co      = rom_dat.co;
    end

endmodule

// File: rtl/common_credit_ctrl5.sv
// Purpose: 5-bit credit controller with alloc/free arbitration and a flush/drain sequence.
// Latency: credit updates one cycle after a handshake; flush_done pulses one cycle after credit returns to INIT_CREDIT.
// Backpressure: alloc_ready drops at zero credit or outside RUN; free_ready drops at MAX_CREDIT.
// Optional build macro COMMON_CREDIT_CTRL5_ERRCHK_EN adds the sticky protocol-error flag.
module common_credit_ctrl5
    import common_credit_pkg::*;
#(
    parameter int INIT_CREDIT = 16,
    parameter int MAX_CREDIT  = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic             free_valid,
    output logic             free_ready,
    input  logic             flush_req,
    output logic             flush_done,
    output logic [CRD_W-1:0] credit,
    output logic             err
);

    localparam logic [CRD_W-1:0] INIT_C = CRD_W'(INIT_CREDIT);
    localparam logic [CRD_W-1:0] MAX_C  = CRD_W'(MAX_CREDIT);

    crd_state_e       state_q;
    crd_state_e       state_d;
    logic [CRD_W-1:0] credit_q;
    logic [CRD_W-1:0] credit_d;

    logic             alloc_fire;
    logic             free_fire;
    logic             rom_dec;
    logic [CRD_W-1:0] rom_q;
    // Carry/borrow never matters: ready gating keeps the counter inside 0..MAX_CREDIT.
    logic             rom_unused_co;

    // Ready signals come only from registers so they never depend on the valids.
    always_comb begin
        alloc_ready = (credit_q != '0) && (state_q == ST_RUN);
        free_ready  = (credit_q != MAX_C);
        alloc_fire  = alloc_valid && alloc_ready;
        free_fire   = free_valid && free_ready;
        rom_dec     = alloc_fire && !free_fire;
    end

    // Single shared inc/dec datapath for both requesters.
    common_rtlrom_decinc5 u_rom (
        .d   (credit_q),
        .dec (rom_dec),
        .q   (rom_q),
        .co  (rom_unused_co)
    );

    // Credit next value: exactly one handshake moves the count; both or neither leaves it alone.
    always_comb begin
        credit_d = credit_q;
        if (alloc_fire ^ free_fire) begin
            credit_d = rom_q;
        end
    end

    // Drain sequencer: RUN -> DRAIN on flush_req, DRAIN -> DONE once credit is home, DONE pulses and returns.
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (credit_q == INIT_C) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                flush_done = 1'b1;
                state_d    = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Credit and state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            credit_q <= INIT_C;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
        end
    end

    assign credit = credit_q;

`ifdef COMMON_CREDIT_CTRL5_ERRCHK_EN
    logic err_q;
    logic err_d;

    // Sticky error: a free offered with no room, or an alloc offered while allocs are blocked by a drain.
    always_comb begin
        err_d = err_q;
        if (free_valid && (credit_q == MAX_C)) begin
            err_d = 1'b1;
        end
        if (alloc_valid && (state_q != ST_RUN) && !flush_req) begin
            err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_common_credit_ctrl5.sv
// Bench for common_credit_ctrl5: directed scenarios then randomized traffic against a behavioural model.
// Two instances: default parameters, and a full-at-reset instance (INIT=MAX=31).
// Expected err behaviour follows COMMON_CREDIT_CTRL5_ERRCHK_EN.
module tb_common_credit_ctrl5;

    localparam int INIT = 16;
    localparam int MAXC = 31;

`ifdef COMMON_CREDIT_CTRL5_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    // Model modes named after the spec's states.
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_DONE  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       alloc_valid = 1'b0;
    logic       free_valid = 1'b0;
    logic       flush_req = 1'b0;
    logic       alloc_ready, free_ready, flush_done, err;
    logic [4:0] credit;

    logic       b_alloc_valid = 1'b0;
    logic       b_free_valid = 1'b0;
    logic       b_flush_req = 1'b0;
    logic       b_alloc_ready, b_free_ready, b_flush_done, b_err;
    logic [4:0] b_credit;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_credit;
    int m_mode;
    bit m_err;

    always #5 clk = ~clk;

    common_credit_ctrl5 #(.INIT_CREDIT(INIT), .MAX_CREDIT(MAXC)) dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .free_valid  (free_valid),
        .free_ready  (free_ready),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .credit      (credit),
        .err         (err)
    );

    common_credit_ctrl5 #(.INIT_CREDIT(31), .MAX_CREDIT(31)) dut_full (
        .clk         (clk),
        .reset       (reset),
        .alloc_valid (b_alloc_valid),
        .alloc_ready (b_alloc_ready),
        .free_valid  (b_free_valid),
        .free_ready  (b_free_ready),
        .flush_req   (b_flush_req),
        .flush_done  (b_flush_done),
        .credit      (b_credit),
        .err         (b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check every DUT output against the model's current view.
    task automatic check_all(input string tag);
        check({tag, ".credit"}, 32'(credit), 32'(m_credit));
        check({tag, ".alloc_ready"}, 32'(alloc_ready), 32'((m_credit != 0) && (m_mode == M_RUN)));
        check({tag, ".free_ready"}, 32'(free_ready), 32'(m_credit != MAXC));
        check({tag, ".flush_done"}, 32'(flush_done), 32'(m_mode == M_DONE));
        check({tag, ".err"}, 32'(err), 32'(m_err));
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        alloc_valid = 1'b0;
        free_valid = 1'b0;
        flush_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_credit = INIT;
        m_mode = M_RUN;
        m_err = 1'b0;
        check_all(tag);
    endtask

    // One clock of traffic on the main instance, with the model advanced from the spec's rules.
    task automatic step(input string tag, input bit av, input bit fv, input bit fq);
        bit a_ok, f_ok;
        int next_mode;
        alloc_valid = av;
        free_valid = fv;
        flush_req = fq;
        a_ok = av && (m_credit > 0) && (m_mode == M_RUN);
        f_ok = fv && (m_credit < MAXC);
        next_mode = m_mode;
        if (m_mode == M_RUN && fq) next_mode = M_DRAIN;
        else if (m_mode == M_DRAIN && m_credit == INIT) next_mode = M_DONE;
        else if (m_mode == M_DONE) next_mode = M_RUN;
        if (ERRCHK && ((fv && m_credit == MAXC) || (av && m_mode != M_RUN && !fq))) m_err = 1'b1;
        @(posedge clk);
        #1;
        m_credit = m_credit - int'(a_ok) + int'(f_ok);
        m_mode = next_mode;
        check_all(tag);
    endtask

    initial begin
        m_credit = INIT;
        m_mode = M_RUN;
        m_err = 1'b0;
        @(posedge clk);
        #1;

        // Reset defaults on both instances.
        do_reset("reset");
        check("full.credit", 32'(b_credit), 32'd31);
        check("full.free_ready", 32'(b_free_ready), 32'd0);
        check("full.alloc_ready", 32'(b_alloc_ready), 32'd1);
        check("full.err", 32'(b_err), 32'd0);

        // Free offered at MAX: refused, credit holds, err only with the checker built.
        b_free_valid = 1'b1;
        @(posedge clk);
        #1;
        b_free_valid = 1'b0;
        check("full.free_hold", 32'(b_credit), 32'd31);
        check("full.err_after_free", 32'(b_err), 32'(ERRCHK));
        b_alloc_valid = 1'b1;
        @(posedge clk);
        #1;
        b_alloc_valid = 1'b0;
        check("full.alloc", 32'(b_credit), 32'd30);
        check("full.free_ready_after", 32'(b_free_ready), 32'd1);

        // Allocate down to zero and one cycle past it.
        for (int i = 0; i < 17; i++) step("alloc_down", 1'b1, 1'b0, 1'b0);
        check("zero_hold", 32'(credit), 32'd0);

        // Climb to 5, then simultaneous alloc and free hold the count.
        for (int i = 0; i < 5; i++) step("free_up", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step("both", 1'b1, 1'b1, 1'b0);
        check("both_hold", 32'(credit), 32'd5);

        // Drain from 12: four frees bring it home, then DONE pulses once.
        for (int i = 0; i < 7; i++) step("to12", 1'b0, 1'b1, 1'b0);
        step("flush", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step("drain_free", 1'b0, 1'b1, 1'b0);
        step("drain_done", 1'b0, 1'b0, 1'b0);
        check("flush_done_pulse", 32'(flush_done), 32'd1);
        step("back_run", 1'b0, 1'b0, 1'b0);
        check("flush_done_clear", 32'(flush_done), 32'd0);

        // Alloc offered while draining (flags err with the checker), then reset mid-drain at 9.
        for (int i = 0; i < 7; i++) step("to9", 1'b1, 1'b0, 1'b0);
        step("flush2", 1'b0, 1'b0, 1'b1);
        step("drain_alloc", 1'b1, 1'b0, 1'b0);
        check("drain_credit9", 32'(credit), 32'd9);
        do_reset("reset_mid_drain");

        // Flush requested when already home: DRAIN exits on its first cycle.
        step("flush_home", 1'b0, 1'b0, 1'b1);
        step("drain_first", 1'b0, 1'b0, 1'b0);
        step("done_first", 1'b0, 1'b0, 1'b0);

        // Randomized traffic with occasional flushes and resets.
        for (int i = 0; i < 800; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 2) begin
                do_reset("rand_reset");
            end else begin
                step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 15) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
